// File: rtl/serial_mag_compare_pkg.sv
// Shared encodings, relation bundle and parameter legality check for serial_mag_compare.
// Two's-complement order is mapped onto unsigned order by flipping operand MSBs on capture.
`ifndef SERIAL_MAG_COMPARE_CHECK
`define SERIAL_MAG_COMPARE_CHECK(W, D) \
    if ((W) < 2 || (D) < 1 || (D) > (W) || ((W) % (D)) != 0) begin : g_param_err \
        $error("serial_mag_compare: illegal WIDTH/DIGIT combination"); \
    end
`endif

package serial_mag_compare_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int REL_W = 5;

    typedef struct packed {
        logic eq;
        logic lt;
        logic le;
        logic gt;
        logic ge;
    } rel_t;

    // Full relation set from one digit decision; equal digits only reach here on the last digit.
    function automatic rel_t rel_from(input logic dgt, input logic dlt);
        rel_t r;
        r.eq = ~dgt & ~dlt;
        r.lt = dlt;
        r.gt = dgt;
        r.le = dlt | r.eq;
        r.ge = dgt | r.eq;
        return r;
    endfunction

endpackage

// File: rtl/serial_mag_compare_digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice; no state, no latency.
module digit_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             dgt_o,
    output logic             dlt_o
);

    assign dgt_o = (a_i > b_i);
    assign dlt_o = (a_i < b_i);

endmodule

// File: rtl/serial_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per clock, early exit on first difference.
// Latency d+1 cycles for first differing digit d (NDIG when equal); start ignored while busy.
module serial_mag_compare
    import serial_mag_compare_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               signed_mode,
    input  logic [WIDTH-1:0]                   x,
    input  logic [WIDTH-1:0]                   y,
    output logic                               busy,
    output logic                               done,
    output logic                               eq,
    output logic                               lt,
    output logic                               le,
    output logic                               gt,
    output logic                               ge,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]   cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    `SERIAL_MAG_COMPARE_CHECK(WIDTH, DIGIT)

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    rel_t             rel_q, rel_d;

    logic             dgt, dlt, last_dig;
    logic [WIDTH-1:0] msb_flip;

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .a_i   (a_q[WIDTH-1 -: DIGIT]),
        .b_i   (b_q[WIDTH-1 -: DIGIT]),
        .dgt_o (dgt),
        .dlt_o (dlt)
    );

    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = x ^ msb_flip;
                    b_d     = y ^ msb_flip;
                    cnt_d   = '0;
                    rel_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // The counter always advances, so on exit it holds the number of digits examined.
                cnt_d = cnt_q + CW'(1);
                if (dgt || dlt || last_dig) begin
                    rel_d   = rel_from(dgt, dlt);
                    state_d = ST_DONE;
                end else begin
                    a_d = a_q << DIGIT;
                    b_d = b_q << DIGIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = (state_q == ST_DONE);
    assign eq     = rel_q.eq;
    assign lt     = rel_q.lt;
    assign le     = rel_q.le;
    assign gt     = rel_q.gt;
    assign ge     = rel_q.ge;
    assign cycles = cnt_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench for serial_mag_compare: three instances (8/2, 4/1, 4/4), vector table, corner sequences, random vs model.
module tb_serial_mag_compare;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] st_v, sm_v;
    logic [2:0] busy_v, done_v, eq_v, lt_v, le_v, gt_v, ge_v;
    logic [7:0] x0, y0;
    logic [3:0] x1, y1, x2, y2;
    logic [2:0] cyc0, cyc1;
    logic [0:0] cyc2;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] R_EQ = 5'b10101; // {eq,lt,le,gt,ge}
    localparam logic [4:0] R_LT = 5'b01100;
    localparam logic [4:0] R_GT = 5'b00011;

    always #5 clk = ~clk;

    serial_mag_compare #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk(clk), .reset(rst), .start(st_v[0]), .signed_mode(sm_v[0]), .x(x0), .y(y0),
        .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .lt(lt_v[0]), .le(le_v[0]),
        .gt(gt_v[0]), .ge(ge_v[0]), .cycles(cyc0));

    serial_mag_compare #(.WIDTH(4), .DIGIT(1)) dut1 (
        .clk(clk), .reset(rst), .start(st_v[1]), .signed_mode(sm_v[1]), .x(x1), .y(y1),
        .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .lt(lt_v[1]), .le(le_v[1]),
        .gt(gt_v[1]), .ge(ge_v[1]), .cycles(cyc1));

    serial_mag_compare #(.WIDTH(4), .DIGIT(4)) dut2 (
        .clk(clk), .reset(rst), .start(st_v[2]), .signed_mode(sm_v[2]), .x(x2), .y(y2),
        .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]), .lt(lt_v[2]), .le(le_v[2]),
        .gt(gt_v[2]), .ge(ge_v[2]), .cycles(cyc2));

    typedef struct {
        int         inst;
        logic [7:0] x;
        logic [7:0] y;
        logic       s;
        logic [4:0] rel;
        int         lat;
        string      nm;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] get_rel(input int i);
        return {eq_v[i], lt_v[i], le_v[i], gt_v[i], ge_v[i]};
    endfunction

    function automatic logic [31:0] get_cyc(input int i);
        case (i)
            0:       return 32'(cyc0);
            1:       return 32'(cyc1);
            default: return 32'(cyc2);
        endcase
    endfunction

    task automatic set_ops(input int i, input logic [7:0] x, input logic [7:0] y, input logic s);
        case (i)
            0: begin x0 = x; y0 = y; end
            1: begin x1 = x[3:0]; y1 = y[3:0]; end
            default: begin x2 = x[3:0]; y2 = y[3:0]; end
        endcase
        sm_v[i] = s;
    endtask

    // Reference: arithmetic compare of the interpreted values; latency from first nonzero digit of x^y.
    task automatic model(input int i, input logic [7:0] x, input logic [7:0] y, input logic s,
                         output logic [4:0] rel, output int lat);
        int w, d, nd, ux, uy, sx, sy, diff;
        w  = (i == 0) ? 8 : 4;
        d  = (i == 0) ? 2 : ((i == 1) ? 1 : 4);
        nd = w / d;
        ux = int'(x) & ((1 << w) - 1);
        uy = int'(y) & ((1 << w) - 1);
        sx = (s && ((ux >> (w - 1)) & 1) != 0) ? ux - (1 << w) : ux;
        sy = (s && ((uy >> (w - 1)) & 1) != 0) ? uy - (1 << w) : uy;
        if (sx == sy)     rel = R_EQ;
        else if (sx < sy) rel = R_LT;
        else              rel = R_GT;
        diff = ux ^ uy;
        lat  = nd;
        for (int k = nd - 1; k >= 0; k--)
            if (((diff >> (w - (k + 1) * d)) & ((1 << d) - 1)) != 0) lat = k + 1;
    endtask

    task automatic run(input int i, input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [4:0] exp_rel, input int exp_lat, input string nm);
        int  lat;
        bit  got;
        set_ops(i, x, y, s);
        st_v[i] = 1'b1;
        @(posedge clk); #1;
        st_v[i] = 1'b0;
        check({nm, " busy_after_start"}, 32'(busy_v[i]), 32'd1);
        check({nm, " done_cleared"}, 32'(done_v[i]), 32'd0);
        check({nm, " rel_cleared"}, 32'(get_rel(i)), 32'd0);
        lat = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done_v[i]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done required=done_within_20", nm);
        end else begin
            check({nm, " latency"}, 32'(lat), 32'(exp_lat));
            check({nm, " relations"}, 32'(get_rel(i)), 32'(exp_rel));
            check({nm, " cycles"}, get_cyc(i), 32'(exp_lat));
            check({nm, " busy_at_done"}, 32'(busy_v[i]), 32'd0);
        end
    endtask

    initial begin
        logic [4:0] mrel;
        int         mlat;
        logic [7:0] rx, ry;
        logic       rs;
        int         ri;

        tbl[0] = '{0, 8'h5A, 8'h5A, 1'b0, R_EQ, 4, "eq_5a"};
        tbl[1] = '{0, 8'h80, 8'h7F, 1'b0, R_GT, 1, "uns_80_7f"};
        tbl[2] = '{0, 8'h80, 8'h7F, 1'b1, R_LT, 1, "sgn_80_7f"};
        tbl[3] = '{0, 8'h13, 8'h12, 1'b0, R_GT, 4, "last_digit"};
        tbl[4] = '{0, 8'h20, 8'h10, 1'b0, R_GT, 2, "digit1"};
        tbl[5] = '{0, 8'hFE, 8'hFF, 1'b1, R_LT, 4, "sgn_m2_m1"};
        tbl[6] = '{1, 8'h01, 8'h00, 1'b0, R_GT, 4, "w4d1_gt"};
        tbl[7] = '{2, 8'h0F, 8'h00, 1'b1, R_LT, 1, "w4d4_sgn"};
        tbl[8] = '{2, 8'h07, 8'h07, 1'b1, R_EQ, 1, "w4d4_eq"};

        rst  = 1'b1;
        st_v = '0;
        sm_v = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset done%0d", i), 32'(done_v[i]), 32'd0);
            check($sformatf("reset rel%0d", i), 32'(get_rel(i)), 32'd0);
            check($sformatf("reset cycles%0d", i), get_cyc(i), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 9; t++)
            run(tbl[t].inst, tbl[t].x, tbl[t].y, tbl[t].s, tbl[t].rel, tbl[t].lat, tbl[t].nm);

        // Start during SCAN is ignored; then start while done=1 is accepted at once.
        set_ops(0, 8'h00, 8'hFF, 1'b0);
        st_v[0] = 1'b1;
        @(posedge clk); #1;
        set_ops(0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        st_v[0] = 1'b0;
        check("hs ignored_start done", 32'(done_v[0]), 32'd1);
        check("hs ignored_start rel", 32'(get_rel(0)), 32'(R_LT));
        check("hs ignored_start cycles", get_cyc(0), 32'd1);
        run(0, 8'h00, 8'h00, 1'b0, R_EQ, 4, "hs_restart");

        // Reset in the second SCAN cycle, with start asserted, wins.
        set_ops(0, 8'h5A, 8'h5A, 1'b0);
        st_v[0] = 1'b1;
        @(posedge clk); #1;
        st_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        st_v[0] = 1'b1;
        @(posedge clk); #1;
        check("rst_mid busy", 32'(busy_v[0]), 32'd0);
        check("rst_mid done", 32'(done_v[0]), 32'd0);
        check("rst_mid rel", 32'(get_rel(0)), 32'd0);
        check("rst_mid cycles", get_cyc(0), 32'd0);
        rst = 1'b0;
        st_v[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_quiet done c%0d", k), 32'(done_v[0] | busy_v[0]), 32'd0);
        end
        run(0, 8'h01, 8'h03, 1'b0, R_LT, 4, "after_rst");

        for (int n = 0; n < 300; n++) begin
            ri = int'($urandom_range(0, 2));
            rx = 8'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? rx : 8'($urandom);
            rs = 1'($urandom);
            if (ri != 0) begin
                rx = rx & 8'h0F;
                ry = ry & 8'h0F;
            end
            model(ri, rx, ry, rs, mrel, mlat);
            run(ri, rx, ry, rs, mrel, mlat, $sformatf("rnd%0d_i%0d_%02h_%02h_s%0d", n, ri, rx, ry, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
